// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   rx_state_e    : receiver FSM state encoding
//   calc_div      : clock cycles per sample tick (integer division)
//   div_in_range  : true when the divider is usable (at least 2)
//   xor_bits      : parity (XOR reduction) over a data word, zero-extended
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP1     = 3'd4,
    RX_STOP2     = 3'd5,
    RX_PUSH      = 3'd6,
    RX_WAIT_HIGH = 3'd7
  } rx_state_e;

  localparam int MAX_DATA_BITS = 9;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

  function automatic bit div_in_range(input int div);
    return div >= 2;
  endfunction

  function automatic logic xor_bits(input logic [MAX_DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Received-frame stream between the UART receiver and its consumer.
//   data       : data of the frame at the FIFO head
//   parity_err : parity mismatch flag of the head frame
//   frame_err  : stop-bit error flag of the head frame
//   valid      : a frame is available
//   ready      : consumer accepts the head frame
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 valid;
  logic                 ready;

  modport master (output data, parity_err, frame_err, valid, input ready);
  modport slave  (input data, parity_err, frame_err, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through frame buffer.
//   clk, resetn : clock, asynchronous active-low reset
//   push, wdata : write request and data
//   pop         : remove the head entry (ignored while empty)
//   rdata       : head entry, zero while empty
//   empty       : no entries stored
//   overrun     : push refused because the buffer is full and not popping
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit on each pointer separates full from empty.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot being written, so a full push is still taken.
  assign push_ok = push && (!full || pop_ok);
  assign overrun = push && full && !pop_ok;
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority-vote bit decision, run-time
// parity / stop-bit configuration, parity, framing and break detection, and a
// FWFT frame buffer on the output.
//   clk, resetn    : clock, asynchronous active-low reset
//   rx_i           : asynchronous serial line, idle high
//   cfg_parity_en  : parity bit follows the data bits
//   cfg_parity_odd : 1 = odd parity, 0 = even parity
//   cfg_two_stop   : check a second stop bit
//   m              : frame stream (data, parity_err, frame_err, valid, ready)
//   overrun        : one-cycle pulse, frame dropped on a full buffer
//   break_det      : one-cycle pulse, break received
//   rx_busy        : receiver is not idle
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for a tick with the line low
// START      | verifying the start bit, false start returns here
// DATA       | shifting data bits in, LSB first
// PARITY     | checking the parity bit
// STOP1      | checking the first stop bit, detecting break
// STOP2      | checking the second stop bit
// PUSH       | one clock, frame written to the buffer
// WAIT_HIGH  | after a break, waiting for the line to return high
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic rx_i,
  input  logic cfg_parity_en,
  input  logic cfg_parity_odd,
  input  logic cfg_two_stop,
  uart_rx_oversampled_if.master m,
  output logic overrun,
  output logic break_det,
  output logic rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int H   = OVERSAMPLE / 2;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (!div_in_range(DIV) || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_param_check
    $fatal(1, "uart_rx_oversampled: unsupported parameter set");
  end

  localparam logic [2:0] S_IDLE      = RX_IDLE;
  localparam logic [2:0] S_START     = RX_START;
  localparam logic [2:0] S_DATA      = RX_DATA;
  localparam logic [2:0] S_PARITY    = RX_PARITY;
  localparam logic [2:0] S_STOP1     = RX_STOP1;
  localparam logic [2:0] S_STOP2     = RX_STOP2;
  localparam logic [2:0] S_PUSH      = RX_PUSH;
  localparam logic [2:0] S_WAIT_HIGH = RX_WAIT_HIGH;

  logic                 rx_meta;
  logic                 rxs;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [SW-1:0]        s;
  logic                 s_last;
  logic                 dec_tick;
  logic                 end_tick;
  logic                 samp_a;
  logic                 samp_b;
  logic                 bit_val;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 start_det;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 two_stop_q;
  logic                 par_bit;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [DATA_BITS+1:0] wdata;
  logic [DATA_BITS+1:0] rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_cnt <= '0;
    else         div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  assign s_last    = (s == SW'(OVERSAMPLE - 1));
  assign dec_tick  = tick && (s == SW'(H + 1));
  assign end_tick  = tick && s_last;
  assign bit_val   = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign start_det = (state == S_IDLE) && tick && !rxs;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (tick && !rxs) state_nxt = S_START;
      S_START: begin
        if (dec_tick && bit_val) state_nxt = S_IDLE;
        else if (end_tick)       state_nxt = S_DATA;
      end
      S_DATA: begin
        if (end_tick && bit_cnt == BW'(DATA_BITS))
          state_nxt = par_en_q ? S_PARITY : S_STOP1;
      end
      S_PARITY:    if (end_tick) state_nxt = S_STOP1;
      S_STOP1: begin
        // Single stop: leave at the decision so the next start edge is not missed.
        if (two_stop_q) begin
          if (end_tick) state_nxt = S_STOP2;
        end else if (dec_tick) begin
          state_nxt = S_PUSH;
        end
      end
      S_STOP2:     if (dec_tick) state_nxt = S_PUSH;
      S_PUSH:      state_nxt = brk ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      s          <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
    end else begin
      state <= state_nxt;

      // s is held at 0 while idle, so the first tick in START is sample 0.
      if (tick) s <= (state == S_IDLE || s_last) ? '0 : s + 1'b1;
      if (tick && s == SW'(H - 1)) samp_a <= rxs;
      if (tick && s == SW'(H))     samp_b <= rxs;

      if (start_det) begin
        par_en_q   <= cfg_parity_en;
        par_odd_q  <= cfg_parity_odd;
        two_stop_q <= cfg_two_stop;
        shreg      <= '0;
        bit_cnt    <= '0;
        par_bit    <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        brk        <= 1'b0;
      end

      if (dec_tick) begin
        case (state)
          S_DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: begin
            par_bit    <= bit_val;
            parity_err <= bit_val ^ xor_bits(MAX_DATA_BITS'(shreg)) ^ par_odd_q;
          end
          S_STOP1: begin
            if (!bit_val) frame_err <= 1'b1;
            brk <= !bit_val && (shreg == '0) && (!par_en_q || !par_bit);
          end
          S_STOP2: begin
            if (!bit_val) frame_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign push      = (state == S_PUSH);
  assign wdata     = {parity_err, frame_err, shreg};
  assign pop       = !empty && m.ready;
  assign break_det = push && brk;
  assign rx_busy   = (state != S_IDLE);

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .empty   (empty),
    .overrun (overrun)
  );

  assign m.data       = rdata[DATA_BITS-1:0];
  assign m.frame_err  = rdata[DATA_BITS];
  assign m.parity_err = rdata[DATA_BITS+1];
  assign m.valid      = !empty;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench: an 8-bit receiver and a 9-bit receiver share clock,
// reset and configuration; each has its own serial line and frame stream.
module tb_uart_rx_oversampled;

  localparam int OS       = 16;
  localparam int DIV      = 27;
  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = DIV * OS * BAUD;
  localparam int BIT      = DIV * OS;
  localparam int H        = OS / 2;
  localparam int LAT_LO   = ((1 + 8) * OS + H + 2) * DIV + 4;
  localparam int LAT_HI   = ((1 + 8) * OS + H + 3) * DIV + 3;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx8 = 1'b1;
  logic rx9 = 1'b1;
  logic cfg_pe = 1'b0;
  logic cfg_po = 1'b0;
  logic cfg_ts = 1'b0;
  logic ovr8, brk8, busy8, ovr9, brk9, busy9;

  exp_t q8[$];
  exp_t q9[$];
  exp_t e8, e9;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   valid_cyc = 0;
  int   lat;
  int   ovr_cnt8 = 0, brk_cnt8 = 0, ovr_cnt9 = 0, brk_cnt9 = 0;
  int   b0, o0;
  logic prev_v8 = 1'b0;

  uart_rx_oversampled_if #(.DATA_BITS(8)) m8 ();
  uart_rx_oversampled_if #(.DATA_BITS(9)) m9 ();

  uart_rx_oversampled #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .FIFO_DEPTH(4)
  ) dut8 (
    .clk(clk), .resetn(resetn), .rx_i(rx8),
    .cfg_parity_en(cfg_pe), .cfg_parity_odd(cfg_po), .cfg_two_stop(cfg_ts),
    .m(m8), .overrun(ovr8), .break_det(brk8), .rx_busy(busy8)
  );

  uart_rx_oversampled #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(9), .FIFO_DEPTH(4)
  ) dut9 (
    .clk(clk), .resetn(resetn), .rx_i(rx9),
    .cfg_parity_en(cfg_pe), .cfg_parity_odd(cfg_po), .cfg_two_stop(cfg_ts),
    .m(m9), .overrun(ovr9), .break_det(brk9), .rx_busy(busy9)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a frame is handed over.
  always @(negedge clk) begin
    if (m8.valid && !prev_v8) valid_cyc = cyc;
    prev_v8 = m8.valid;
    if (ovr8) ovr_cnt8++;
    if (brk8) brk_cnt8++;
    if (ovr9) ovr_cnt9++;
    if (brk9) brk_cnt9++;
    if (resetn && m8.valid && m8.ready) begin
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL frame8_unexpected: got data=%h pe=%b fe=%b, required no frame",
                 m8.data, m8.parity_err, m8.frame_err);
      end else begin
        e8 = q8.pop_front();
        if (m8.data !== e8.data[7:0] || m8.parity_err !== e8.pe || m8.frame_err !== e8.fe) begin
          n_fail++;
          $display("FAIL frame8: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   m8.data, m8.parity_err, m8.frame_err, e8.data[7:0], e8.pe, e8.fe);
        end
      end
    end
    if (resetn && m9.valid && m9.ready) begin
      n_tests++;
      if (q9.size() == 0) begin
        n_fail++;
        $display("FAIL frame9_unexpected: got data=%h pe=%b fe=%b, required no frame",
                 m9.data, m9.parity_err, m9.frame_err);
      end else begin
        e9 = q9.pop_front();
        if (m9.data !== e9.data || m9.parity_err !== e9.pe || m9.frame_err !== e9.fe) begin
          n_fail++;
          $display("FAIL frame9: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   m9.data, m9.parity_err, m9.frame_err, e9.data, e9.pe, e9.fe);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_valid8"}, m8.valid, 0);
    check({tag, "_data8"}, m8.data, 0);
    check({tag, "_pe8"}, m8.parity_err, 0);
    check({tag, "_fe8"}, m8.frame_err, 0);
    check({tag, "_ovr8"}, ovr8, 0);
    check({tag, "_brk8"}, brk8, 0);
    check({tag, "_busy8"}, busy8, 0);
    check({tag, "_valid9"}, m9.valid, 0);
    check({tag, "_data9"}, m9.data, 0);
    check({tag, "_pe9"}, m9.parity_err, 0);
    check({tag, "_fe9"}, m9.frame_err, 0);
    check({tag, "_ovr9"}, ovr9, 0);
    check({tag, "_brk9"}, brk9, 0);
    check({tag, "_busy9"}, busy9, 0);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 9) rx9 = v;
    else            rx8 = v;
  endtask

  task automatic hold_bits(input int which, input logic v, input int n);
    set_rx(which, v);
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input logic par_en, input logic par_bit,
                            input int nstop, input logic stop_val);
    @(negedge clk);
    fall_cyc = cyc;
    hold_bits(which, 1'b0, 1);
    for (int i = 0; i < nbits; i++) hold_bits(which, data[i], 1);
    if (par_en) hold_bits(which, par_bit, 1);
    for (int i = 0; i < nstop; i++) hold_bits(which, stop_val, 1);
    set_rx(which, 1'b1);
  endtask

  initial begin
    m8.ready = 1'b1;
    m9.ready = 1'b1;
    repeat (5) @(negedge clk);
    rst_checks("reset");
    resetn = 1'b1;
    hold_bits(8, 1'b1, 1);

    // 8N1 frame and output latency
    q8.push_back('{data: 9'h0A5, pe: 1'b0, fe: 1'b0});
    send_frame(8, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    lat = valid_cyc - fall_cyc;
    n_tests++;
    if (lat < LAT_LO || lat > LAT_HI) begin
      n_fail++;
      $display("FAIL t1_valid_latency: got %0d clocks, required %0d..%0d", lat, LAT_LO, LAT_HI);
    end
    hold_bits(8, 1'b1, 1);

    // Even parity, wrong then right; config change mid-frame must be ignored
    cfg_pe = 1'b1;
    cfg_po = 1'b0;
    q8.push_back('{data: 9'h037, pe: 1'b1, fe: 1'b0});
    send_frame(8, 9'h037, 8, 1'b1, 1'b0, 1, 1'b1);
    hold_bits(8, 1'b1, 1);
    q8.push_back('{data: 9'h037, pe: 1'b0, fe: 1'b0});
    fork
      begin
        repeat (3 * BIT) @(negedge clk);
        cfg_po = 1'b1;
        cfg_pe = 1'b0;
      end
    join_none
    send_frame(8, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
    cfg_pe = 1'b0;
    cfg_po = 1'b0;
    hold_bits(8, 1'b1, 1);

    // Framing error, then break, then recovery
    b0 = brk_cnt8;
    q8.push_back('{data: 9'h055, pe: 1'b0, fe: 1'b1});
    send_frame(8, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
    hold_bits(8, 1'b1, 2);
    check("t3_no_break_on_frame_err", brk_cnt8 - b0, 0);
    q8.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b1});
    hold_bits(8, 1'b0, 20);
    hold_bits(8, 1'b1, 2);
    check("t3_break_pulses", brk_cnt8 - b0, 1);
    q8.push_back('{data: 9'h0C3, pe: 1'b0, fe: 1'b0});
    send_frame(8, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
    hold_bits(8, 1'b1, 1);
    check("t3_break_pulses_after_recovery", brk_cnt8 - b0, 1);

    // Glitch rejection
    o0 = ovr_cnt8;
    b0 = brk_cnt8;
    @(negedge clk);
    rx8 = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx8 = 1'b1;
    check("t4_busy_in_start", busy8, 1);
    repeat (H * DIV + 8) @(negedge clk);
    check("t4_busy_after_decision", busy8, 0);
    hold_bits(8, 1'b1, 2);
    check("t4_no_frame", m8.valid, 0);
    check("t4_no_overrun", ovr_cnt8 - o0, 0);
    check("t4_no_break", brk_cnt8 - b0, 0);

    // Overrun with the consumer stalled
    @(negedge clk);
    m8.ready = 1'b0;
    o0 = ovr_cnt8;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q8.push_back('{data: 9'(i), pe: 1'b0, fe: 1'b0});
      send_frame(8, 9'(i), 8, 1'b0, 1'b0, 1, 1'b1);
      if (i == 4) check("t5_no_overrun_before_5th", ovr_cnt8 - o0, 0);
    end
    check("t5_overrun_on_5th", ovr_cnt8 - o0, 1);
    check("t5_valid_while_stalled", m8.valid, 1);
    check("t5_head_still_first", m8.data, 1);
    @(negedge clk);
    m8.ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_empty_after_drain", m8.valid, 0);
    check("t5_scoreboard_drained", q8.size(), 0);

    // Reset mid-frame, then 9 data bits, odd parity, two stop bits
    cfg_pe = 1'b1;
    cfg_po = 1'b1;
    cfg_ts = 1'b1;
    @(negedge clk);
    hold_bits(9, 1'b0, 1);
    for (int i = 0; i < 3; i++) hold_bits(9, 1'b1, 1);
    rx9 = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("t6_busy_before_reset", busy9, 1);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    rst_checks("t6_reset");
    resetn = 1'b1;
    hold_bits(9, 1'b1, 2);
    q9.push_back('{data: 9'h03C, pe: 1'b0, fe: 1'b0});
    send_frame(9, 9'h03C, 9, 1'b1, 1'b1, 2, 1'b1);
    hold_bits(9, 1'b1, 1);

    check("end_q8_empty", q8.size(), 0);
    check("end_q9_empty", q9.size(), 0);
    check("end_ovr9", ovr_cnt9, 0);
    check("end_brk9", brk_cnt9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
